// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered one-hot bus multiplexer with source reporting and
// multi-driver conflict detection (sticky flag plus saturating counter).
module bus_mux_reg #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 24,
  parameter int HOLD_LAST = 1,
  parameter int CNT_W     = 8,
  localparam int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [WIDTH*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         bus_sel,
  output logic                     conflict,
  output logic                     conflict_sticky,
  output logic [CNT_W-1:0]         conflict_cnt
);
  logic [SEL_W-1:0] winIdx;
  logic [WIDTH-1:0] winData;
  logic             anyEn;
  logic             multiEn;
  logic             cntSat;
  // Priority encoder: lowest set enable wins, a second set bit flags a conflict.
  always_comb begin
    winIdx  = '0;
    anyEn   = 1'b0;
    multiEn = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_en[i]) begin
        if (anyEn) multiEn = 1'b1;
        else begin
          winIdx = SEL_W'(i);
          anyEn  = 1'b1;
        end
      end
    end
    winData = src_data[int'(winIdx)*WIDTH +: WIDTH];
    cntSat  = &conflict_cnt;
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      bus_out         <= '0;
      bus_valid       <= 1'b0;
      bus_sel         <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      bus_valid <= anyEn;
      conflict  <= multiEn;
      if (anyEn) begin
        bus_out <= winData;
        bus_sel <= winIdx;
      end else if (HOLD_LAST == 0) begin
        bus_out <= '0;
      end
      // A conflict in the same cycle as err_clr restarts the count at one.
      if (multiEn) begin
        conflict_sticky <= 1'b1;
        conflict_cnt    <= err_clr ? CNT_W'(1) : conflict_cnt + CNT_W'(!cntSat);
      end else if (err_clr) begin
        conflict_sticky <= 1'b0;
        conflict_cnt    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_mux_reg.sv
// tb_bus_mux_reg: directed self-checking bench for bus_mux_reg (HOLD_LAST=1
// and HOLD_LAST=0 instances share the same stimulus).
module tb_bus_mux_reg;
  logic         clk = 1'b0;
  logic         clear;
  logic [767:0] srcData;
  logic [23:0]  srcEn;
  logic         errClr;
  logic [31:0]  busOut, busOut0;
  logic         busValid, busValid0;
  logic [4:0]   busSel, busSel0;
  logic         conf, conf0, sticky, sticky0;
  logic [7:0]   cnt, cnt0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  bus_mux_reg dut (
    .clk(clk), .clear(clear), .src_data(srcData), .src_en(srcEn), .err_clr(errClr),
    .bus_out(busOut), .bus_valid(busValid), .bus_sel(busSel), .conflict(conf),
    .conflict_sticky(sticky), .conflict_cnt(cnt)
  );

  bus_mux_reg #(.HOLD_LAST(0)) dutZero (
    .clk(clk), .clear(clear), .src_data(srcData), .src_en(srcEn), .err_clr(errClr),
    .bus_out(busOut0), .bus_valid(busValid0), .bus_sel(busSel0), .conflict(conf0),
    .conflict_sticky(sticky0), .conflict_cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".out"}, busOut, 0);
    chk({tag, ".valid"}, 32'(busValid), 0);
    chk({tag, ".sel"}, 32'(busSel), 0);
    chk({tag, ".conf"}, 32'(conf), 0);
    chk({tag, ".sticky"}, 32'(sticky), 0);
    chk({tag, ".cnt"}, 32'(cnt), 0);
  endtask

  initial begin
    clear   = 1'b0;
    errClr  = 1'b0;
    srcData = '0;
    srcData[31:0] = 32'hDEADBEEF;
    srcEn   = 24'h000001;
    cyc();
    cyc();
    chkAllZero("rst");
    @(negedge clk);
    clear = 1'b1;
    cyc();
    chk("rel.out", busOut, 32'hDEADBEEF);
    chk("rel.sel", 32'(busSel), 0);
    chk("rel.valid", 32'(busValid), 1);

    for (int i = 0; i < 24; i++) begin
      srcData[i*32 +: 32] = 32'hA5000000 + 32'(i);
      srcEn = 24'h1 << i;
      cyc();
      chk($sformatf("walk%0d.out", i), busOut, 32'hA5000000 + 32'(i));
      chk($sformatf("walk%0d.sel", i), 32'(busSel), 32'(i));
      chk($sformatf("walk%0d.valid", i), 32'(busValid), 1);
      chk($sformatf("walk%0d.conf", i), 32'(conf), 0);
    end

    srcData[20*32 +: 32] = 32'h00000100;
    srcEn = 24'h1 << 20;
    cyc();
    chk("pc.out", busOut, 32'h100);
    chk("pc.out0", busOut0, 32'h100);
    srcEn = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("idle%0d.out", k), busOut, 32'h100);
      chk($sformatf("idle%0d.sel", k), 32'(busSel), 20);
      chk($sformatf("idle%0d.valid", k), 32'(busValid), 0);
      chk($sformatf("idle%0d.out0", k), busOut0, 0);
      chk($sformatf("idle%0d.sel0", k), 32'(busSel0), 20);
    end
    chk("pre.sticky", 32'(sticky), 0);

    srcData[3*32 +: 32]  = 32'h11111111;
    srcData[17*32 +: 32] = 32'h22222222;
    srcEn = (24'h1 << 3) | (24'h1 << 17);
    cyc();
    chk("cf.out", busOut, 32'h11111111);
    chk("cf.sel", 32'(busSel), 3);
    chk("cf.valid", 32'(busValid), 1);
    chk("cf.conf", 32'(conf), 1);
    chk("cf.sticky", 32'(sticky), 1);
    chk("cf.cnt", 32'(cnt), 1);
    srcEn = '0;
    cyc();
    chk("cf2.conf", 32'(conf), 0);
    chk("cf2.sticky", 32'(sticky), 1);
    chk("cf2.cnt", 32'(cnt), 1);

    srcEn = (24'h1 << 3) | (24'h1 << 17);
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (k == 1) chk("sat.cnt2", 32'(cnt), 3);
    end
    chk("sat.cnt", 32'(cnt), 255);
    chk("sat.conf", 32'(conf), 1);

    srcEn  = '0;
    errClr = 1'b1;
    cyc();
    chk("clr.sticky", 32'(sticky), 0);
    chk("clr.cnt", 32'(cnt), 0);
    chk("clr.conf", 32'(conf), 0);
    srcEn = (24'h1 << 3) | (24'h1 << 17);
    cyc();
    chk("clrcf.sticky", 32'(sticky), 1);
    chk("clrcf.cnt", 32'(cnt), 1);
    chk("clrcf.conf", 32'(conf), 1);
    errClr = 1'b0;
    cyc();
    chk("cnt.inc", 32'(cnt), 2);

    srcData[5*32 +: 32] = 32'hCAFEF00D;
    srcEn = 24'h1 << 5;
    cyc();
    chk("mid.out", busOut, 32'hCAFEF00D);
    chk("mid.cntkept", 32'(cnt), 2);
    #2;
    clear = 1'b0;
    #1;
    chkAllZero("arst");
    @(negedge clk);
    chkAllZero("arst2");
    clear = 1'b1;
    cyc();
    chk("post.out", busOut, 32'hCAFEF00D);
    chk("post.sel", 32'(busSel), 5);
    chk("post.valid", 32'(busValid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
